// File: rtl/proc_pkg.sv
// proc_pkg
// Shared definitions for the proc_core multi-cycle CPU slice:
//   - FSM state, opcode and R-type ALU operation enums
//   - exception (status) codes written to r30 on arithmetic overflow
//   - fixed register indices for the status register and return address
//   - small decode helpers (immediate sign extension, R-type exception code)
// Optional feature macro used by the slice: MULDIV_EN (enables mul/div).
package proc_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_MEM   = 2'd2
    } state_e;

    typedef enum logic [4:0] {
        OP_RTYPE = 5'b00000,
        OP_J     = 5'b00001,
        OP_BNE   = 5'b00010,
        OP_JAL   = 5'b00011,
        OP_JR    = 5'b00100,
        OP_ADDI  = 5'b00101,
        OP_BLT   = 5'b00110,
        OP_SW    = 5'b00111,
        OP_LW    = 5'b01000,
        OP_SETX  = 5'b10101,
        OP_BEX   = 5'b10110
    } opcode_e;

    typedef enum logic [4:0] {
        ALU_ADD = 5'b00000,
        ALU_SUB = 5'b00001,
        ALU_AND = 5'b00010,
        ALU_OR  = 5'b00011,
        ALU_SLL = 5'b00100,
        ALU_SRA = 5'b00101,
        ALU_MUL = 5'b00110,
        ALU_DIV = 5'b00111
    } aluop_e;

    localparam logic [31:0] EXC_ADD  = 32'd1;
    localparam logic [31:0] EXC_ADDI = 32'd2;
    localparam logic [31:0] EXC_SUB  = 32'd3;
    localparam logic [31:0] EXC_MUL  = 32'd4;
    localparam logic [31:0] EXC_DIV  = 32'd5;

    localparam logic [4:0] R_STATUS = 5'd30;
    localparam logic [4:0] R_RA     = 5'd31;

    function automatic logic [31:0] sext17(input logic [16:0] v);
        return {{15{v[16]}}, v};
    endfunction

    // Only add/sub/mul/div can overflow; the logical and shift ops never
    // raise the flag, so their entry here is never used.
    function automatic logic [31:0] rtype_exc(input aluop_e op);
        logic [31:0] code;
        case (op)
            ALU_SUB: code = EXC_SUB;
            ALU_MUL: code = EXC_MUL;
            ALU_DIV: code = EXC_DIV;
            default: code = EXC_ADD;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/proc_alu.sv
// proc_alu
// Purely combinational ALU for proc_core.
// Ports:
//   a, b      : operands (a = rs data, b = rt data or sign-extended immediate)
//   shamt     : shift amount for sll/sra
//   op        : operation select
//   result    : 32-bit result (two's complement, mod 2^32)
//   overflow  : signed overflow / divide exception
//   op_valid  : high when op is an implemented operation
//   ne, lt    : branch flags, ne = (a != b), lt = signed(b) < signed(a)
// Macro MULDIV_EN: when defined, mul and div are implemented; otherwise they
// report op_valid = 0 so the core treats them as no-ops.
module proc_alu
    import proc_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  shamt,
    input  aluop_e      op,
    output logic [31:0] result,
    output logic        overflow,
    output logic        op_valid,
    output logic        ne,
    output logic        lt
);

    logic [31:0] sum;
    logic [31:0] diff;

    assign sum  = a + b;
    assign diff = a - b;

    // The branch flags compare B against A because bne/blt test $rd against $rs.
    assign ne = (a != b);
    assign lt = ($signed(b) < $signed(a));

`ifdef MULDIV_EN
    logic signed [63:0] product;
    logic signed [31:0] quotient;
    logic               div_bad;

    assign product  = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    // Both divide-by-zero and the single unrepresentable quotient
    // (-2^31 / -1) are exceptions, so the divider never sees them.
    assign div_bad  = (b == 32'd0) || ((a == 32'h8000_0000) && (b == 32'hFFFF_FFFF));
    assign quotient = div_bad ? 32'sd0 : ($signed(a) / $signed(b));
`endif

    always_comb begin
        result   = 32'd0;
        overflow = 1'b0;
        op_valid = 1'b1;
        case (op)
            ALU_ADD: begin
                result   = sum;
                overflow = (a[31] == b[31]) && (sum[31] != a[31]);
            end
            ALU_SUB: begin
                result   = diff;
                overflow = (a[31] != b[31]) && (diff[31] != a[31]);
            end
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_SLL: result = a << shamt;
            ALU_SRA: result = $signed(a) >>> shamt;
`ifdef MULDIV_EN
            ALU_MUL: begin
                result   = product[31:0];
                overflow = (product[63:32] != {32{product[31]}});
            end
            ALU_DIV: begin
                result   = quotient;
                overflow = div_bad;
            end
`endif
            default: op_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/proc_core.sv
// proc_core
// Non-pipelined multi-cycle 32-bit CPU core. Storage (ROM, RAM, register
// file) lives outside; this block owns only the PC and the FSM state.
// Ports:
//   clock, reset       : system clock, asynchronous active-high reset
//   address_imem       : instruction address (= PC)
//   q_imem             : registered ROM data for address_imem
//   ctrl_writeEnable   : register file write enable
//   ctrl_writeReg      : register file write index
//   ctrl_readRegA/B    : register file read indices
//   data_writeReg      : register file write data
//   data_readRegA/B    : combinational register file read data
//   wren               : RAM write enable
//   address_dmem, data : RAM address and write data
//   q_dmem             : registered RAM read data
// Each instruction spends one cycle in FETCH (ROM registers the word), one in
// EXEC (decode, execute, commit), and lw adds MEM (RAM registers the word).
// Macro MULDIV_EN: enables the mul/div R-type operations in proc_alu.
module proc_core
    import proc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'd0
)(
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] address_imem,
    input  logic [31:0] q_imem,
    output logic        ctrl_writeEnable,
    output logic [4:0]  ctrl_writeReg,
    output logic [4:0]  ctrl_readRegA,
    output logic [4:0]  ctrl_readRegB,
    output logic [31:0] data_writeReg,
    input  logic [31:0] data_readRegA,
    input  logic [31:0] data_readRegB,
    output logic        wren,
    output logic [31:0] address_dmem,
    output logic [31:0] data,
    input  logic [31:0] q_dmem
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;

    opcode_e     opcode;
    aluop_e      aluop;
    logic [4:0]  rd, rs, rt, shamt;
    logic [31:0] imm, tgt, pc_inc;
    logic        unused_bits;

    logic        use_imm;
    aluop_e      alu_op;
    logic [31:0] alu_b, alu_result;
    logic        alu_ovf, alu_valid, alu_ne, alu_lt;

    logic        write_req;

    assign opcode      = opcode_e'(q_imem[31:27]);
    assign rd          = q_imem[26:22];
    assign rs          = q_imem[21:17];
    assign rt          = q_imem[16:12];
    assign shamt       = q_imem[11:7];
    assign aluop       = aluop_e'(q_imem[6:2]);
    assign imm         = sext17(q_imem[16:0]);
    assign tgt         = {5'd0, q_imem[26:0]};
    assign unused_bits = ^q_imem[1:0];
    assign pc_inc      = pc_q + 32'd1;

    assign address_imem = pc_q;

    // Port B selection: stores and branches read $rd, bex reads the status
    // register, everything else reads $rt.
    always_comb begin
        ctrl_readRegA = rs;
        ctrl_readRegB = rt;
        case (opcode)
            OP_SW, OP_BNE, OP_BLT, OP_JR: ctrl_readRegB = rd;
            OP_BEX:                       ctrl_readRegB = R_STATUS;
            default:                      ctrl_readRegB = rt;
        endcase
    end

    // addi/lw/sw add the immediate to $rs; only R-type uses its own aluop.
    always_comb begin
        use_imm = (opcode == OP_ADDI) || (opcode == OP_SW) || (opcode == OP_LW);
        alu_b   = use_imm ? imm : data_readRegB;
        alu_op  = (opcode == OP_RTYPE) ? aluop : ALU_ADD;
    end

    proc_alu u_alu (
        .a        (data_readRegA),
        .b        (alu_b),
        .shamt    (shamt),
        .op       (alu_op),
        .result   (alu_result),
        .overflow (alu_ovf),
        .op_valid (alu_valid),
        .ne       (alu_ne),
        .lt       (alu_lt)
    );

    // The RAM address is held through MEM so the registered read stays tied
    // to the lw effective address.
    assign address_dmem = alu_result;
    assign data         = data_readRegB;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Next-state, PC and commit logic. Register and PC updates both land on
    // the edge that leaves EXEC (or MEM for lw), so reset asserted before that
    // edge returns the FSM to FETCH and cancels the write.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        write_req     = 1'b0;
        ctrl_writeReg = rd;
        data_writeReg = alu_result;
        wren          = 1'b0;
        case (state_q)
            ST_FETCH: begin
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                state_d = ST_FETCH;
                pc_d    = pc_inc;
                case (opcode)
                    OP_RTYPE: begin
                        if (alu_valid) begin
                            write_req = 1'b1;
                            if (alu_ovf) begin
                                ctrl_writeReg = R_STATUS;
                                data_writeReg = rtype_exc(aluop);
                            end
                        end
                    end
                    OP_ADDI: begin
                        write_req = 1'b1;
                        if (alu_ovf) begin
                            ctrl_writeReg = R_STATUS;
                            data_writeReg = EXC_ADDI;
                        end
                    end
                    OP_SW: begin
                        wren = 1'b1;
                    end
                    OP_LW: begin
                        state_d = ST_MEM;
                        pc_d    = pc_q;
                    end
                    OP_BNE: begin
                        if (alu_ne) begin
                            pc_d = pc_inc + imm;
                        end
                    end
                    OP_BLT: begin
                        if (alu_lt) begin
                            pc_d = pc_inc + imm;
                        end
                    end
                    OP_J: begin
                        pc_d = tgt;
                    end
                    OP_JAL: begin
                        write_req     = 1'b1;
                        ctrl_writeReg = R_RA;
                        data_writeReg = pc_inc;
                        pc_d          = tgt;
                    end
                    OP_JR: begin
                        pc_d = data_readRegB;
                    end
                    OP_BEX: begin
                        if (data_readRegB != 32'd0) begin
                            pc_d = tgt;
                        end
                    end
                    OP_SETX: begin
                        write_req     = 1'b1;
                        ctrl_writeReg = R_STATUS;
                        data_writeReg = tgt;
                    end
                    default: begin
                    end
                endcase
            end
            ST_MEM: begin
                state_d       = ST_FETCH;
                pc_d          = pc_inc;
                write_req     = 1'b1;
                data_writeReg = q_dmem;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // r0 is hardwired to zero, so writes to it are dropped here.
    assign ctrl_writeEnable = write_req && (ctrl_writeReg != 5'd0);

endmodule

// File: tb/tb_proc_core.sv
// tb_proc_core
// Bench for proc_core: models the ROM, RAM and register file around the core,
// loads small hand-assembled programs and checks every register write against
// a queue of hand-computed expected writes, plus a few PC/final-state checks.
// Honours MULDIV_EN to choose the expected mul/div behaviour.
module tb_proc_core;

    localparam logic [4:0] OP_R = 5'b00000, OP_J = 5'b00001, OP_BNE = 5'b00010,
                           OP_JAL = 5'b00011, OP_JR = 5'b00100, OP_ADDI = 5'b00101,
                           OP_BLT = 5'b00110, OP_SW = 5'b00111, OP_LW = 5'b01000,
                           OP_SETX = 5'b10101, OP_BEX = 5'b10110;
    localparam logic [4:0] F_ADD = 5'd0, F_SUB = 5'd1, F_SLL = 5'd4,
                           F_MUL = 5'd6, F_DIV = 5'd7;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] address_imem, q_imem;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg, ctrl_readRegA, ctrl_readRegB;
    logic [31:0] data_writeReg, data_readRegA, data_readRegB;
    logic        wren;
    logic [31:0] address_dmem, data, q_dmem;

    logic [31:0] rom  [0:255];
    logic [31:0] ram  [0:255];
    logic [31:0] regs [0:31];

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] val;
        int          cyc;
    } wr_t;

    wr_t sb[$];
    int  compared   = 0;
    int  mismatched = 0;
    int  cyc        = 0;
    int  wren_count = 0;

    proc_core #(.RESET_PC(32'd0)) dut (
        .clock            (clock),
        .reset            (reset),
        .address_imem     (address_imem),
        .q_imem           (q_imem),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .ctrl_readRegA    (ctrl_readRegA),
        .ctrl_readRegB    (ctrl_readRegB),
        .data_writeReg    (data_writeReg),
        .data_readRegA    (data_readRegA),
        .data_readRegB    (data_readRegB),
        .wren             (wren),
        .address_dmem     (address_dmem),
        .data             (data),
        .q_dmem           (q_dmem)
    );

    always #5 clock = ~clock;

    // Synchronous ROM: registers the word one edge after the address.
    always @(posedge clock) q_imem <= rom[address_imem[7:0]];

    // Synchronous RAM, cleared while reset is held.
    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) ram[i] <= 32'd0;
            q_dmem <= 32'd0;
        end else begin
            if (wren) ram[address_dmem[7:0]] <= data;
            q_dmem <= ram[address_dmem[7:0]];
        end
    end

    // Register file: combinational reads, posedge write, cleared in reset.
    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
        end else if (ctrl_writeEnable && ctrl_writeReg != 5'd0) begin
            regs[ctrl_writeReg] <= data_writeReg;
        end
    end
    assign data_readRegA = regs[ctrl_readRegA];
    assign data_readRegB = regs[ctrl_readRegB];

    // Cycle index since reset release; cycle 0 is the first FETCH.
    always @(posedge clock or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Monitor: every write the core presents must match the next queued one.
    always @(negedge clock) begin
        wr_t e;
        if (wren) wren_count++;
        if (ctrl_writeEnable) begin
            if (sb.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_write: got r%0d <= %h, expected no write (cycle %0d)",
                         ctrl_writeReg, data_writeReg, cyc);
            end else begin
                e = sb.pop_front();
                check_output("write_reg", {27'd0, ctrl_writeReg}, {27'd0, e.rd});
                check_output("write_data", data_writeReg, e.val);
                if (e.cyc >= 0) check_output("write_cycle", cyc, e.cyc);
            end
        end
    end

    function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] sh,
                                          input logic [4:0] fn);
        return {OP_R, rd, rs, rt, sh, fn, 2'b00};
    endfunction

    function automatic logic [31:0] enc_i(input logic [4:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs, input int imm);
        logic [31:0] iv;
        iv = imm;
        return {op, rd, rs, iv[16:0]};
    endfunction

    function automatic logic [31:0] enc_j(input logic [4:0] op, input int t);
        logic [31:0] tv;
        tv = t;
        return {op, tv[26:0]};
    endfunction

    task automatic expect_write(input logic [4:0] rd, input logic [31:0] val, input int c);
        wr_t e;
        e.rd  = rd;
        e.val = val;
        e.cyc = c;
        sb.push_back(e);
    endtask

    // Holds the core in reset, checks the reset outputs and blanks the ROM.
    task automatic apply_stimulus(input string name);
        $display("[TB] test %s", name);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check_output("reset_pc", address_imem, 32'd0);
        check_output("reset_we", {31'd0, ctrl_writeEnable}, 32'd0);
        check_output("reset_wren", {31'd0, wren}, 32'd0);
        for (int i = 0; i < 256; i++) rom[i] = 32'd0;
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        wren_count = 0;
        reset = 1'b0;
    endtask

    task automatic wait_cycle(input int n);
        int guard = 0;
        while (cyc != n && guard < 500) begin
            @(negedge clock);
            guard++;
        end
        check_output("cycle_reached", cyc, n);
    endtask

    task automatic end_test(input int n);
        wait_cycle(n);
        check_output("pending_writes", sb.size(), 32'd0);
        sb.delete();
    endtask

    initial begin
        // addi/addi/add with write timing at cycles 1, 3, 5.
        apply_stimulus("add_basic");
        rom[0] = enc_i(OP_ADDI, 1, 0, 5);
        rom[1] = enc_i(OP_ADDI, 2, 0, 7);
        rom[2] = enc_r(3, 1, 2, 0, F_ADD);
        expect_write(1, 32'd5, 1);
        expect_write(2, 32'd7, 3);
        expect_write(3, 32'd12, 5);
        release_reset();
        end_test(10);
        check_output("r3_final", regs[3], 32'd12);

        // sll to the sign bit, then sub that must not overflow.
        apply_stimulus("sll_sub");
        rom[0] = enc_i(OP_ADDI, 1, 0, -1);
        rom[1] = enc_r(4, 1, 0, 31, F_SLL);
        rom[2] = enc_r(5, 4, 1, 0, F_SUB);
        expect_write(1, 32'hFFFF_FFFF, 1);
        expect_write(4, 32'h8000_0000, 3);
        expect_write(5, 32'h8000_0001, 5);
        release_reset();
        end_test(10);

        // add overflow diverts the write to r30.
        apply_stimulus("add_overflow");
        rom[0] = enc_i(OP_ADDI, 1, 0, 1);
        rom[1] = enc_r(1, 1, 0, 30, F_SLL);
        rom[2] = enc_r(2, 1, 1, 0, F_ADD);
        expect_write(1, 32'd1, -1);
        expect_write(1, 32'h4000_0000, -1);
        expect_write(30, 32'd1, 5);
        release_reset();
        end_test(10);
        check_output("r2_unchanged", regs[2], 32'd0);
        check_output("r30_status", regs[30], 32'd1);

        // sw then lw; lw commits at cycle 6 and the next fetch starts at 7.
        apply_stimulus("sw_lw");
        rom[0] = enc_i(OP_ADDI, 1, 0, 9);
        rom[1] = enc_i(OP_SW, 1, 0, 4);
        rom[2] = enc_i(OP_LW, 6, 0, 4);
        expect_write(1, 32'd9, 1);
        expect_write(6, 32'd9, 6);
        release_reset();
        wait_cycle(6);
        check_output("lw_mem_pc", address_imem, 32'd2);
        wait_cycle(7);
        check_output("after_lw_pc", address_imem, 32'd3);
        end_test(12);
        check_output("wren_pulses", wren_count, 32'd1);
        check_output("r6_final", regs[6], 32'd9);

        // Loop with jal/bne/blt/jr; ends spinning on j 2.
        apply_stimulus("branch_loop");
        rom[0] = enc_i(OP_ADDI, 8, 0, 3);
        rom[1] = enc_j(OP_JAL, 4);
        rom[2] = enc_j(OP_J, 2);
        rom[4] = enc_i(OP_ADDI, 7, 7, 1);
        rom[5] = enc_i(OP_BNE, 7, 8, -2);
        rom[6] = enc_i(OP_BLT, 7, 8, -3);
        rom[7] = enc_i(OP_BLT, 0, 7, 1);
        rom[8] = enc_i(OP_ADDI, 9, 0, 1);
        rom[9] = enc_i(OP_JR, 31, 0, 0);
        expect_write(8, 32'd3, 1);
        expect_write(31, 32'd2, 3);
        expect_write(7, 32'd1, 5);
        expect_write(7, 32'd2, 9);
        expect_write(7, 32'd3, 13);
        release_reset();
        end_test(40);
        check_output("loop_pc", address_imem, 32'd2);
        check_output("r7_final", regs[7], 32'd3);
        check_output("r31_final", regs[31], 32'd2);
        check_output("r9_skipped", regs[9], 32'd0);

        // bex not taken on r30 = 0, setx, then bex taken.
        apply_stimulus("bex_setx");
        rom[0] = enc_j(OP_BEX, 5);
        rom[1] = enc_j(OP_SETX, 7);
        rom[2] = enc_j(OP_BEX, 5);
        rom[3] = enc_i(OP_ADDI, 9, 0, 1);
        rom[5] = enc_j(OP_J, 5);
        expect_write(30, 32'd7, 3);
        release_reset();
        end_test(20);
        check_output("bex_pc", address_imem, 32'd5);

        // mul/div, including divide by zero.
        apply_stimulus("muldiv");
        rom[0] = enc_i(OP_ADDI, 1, 0, 6);
        rom[1] = enc_i(OP_ADDI, 2, 0, -3);
        rom[2] = enc_r(3, 1, 2, 0, F_MUL);
        rom[3] = enc_r(4, 1, 2, 0, F_DIV);
        rom[4] = enc_r(5, 1, 0, 0, F_DIV);
        expect_write(1, 32'd6, 1);
        expect_write(2, 32'hFFFF_FFFD, 3);
`ifdef MULDIV_EN
        expect_write(3, 32'hFFFF_FFEE, 5);
        expect_write(4, 32'hFFFF_FFFE, 7);
        expect_write(30, 32'd5, 9);
`endif
        release_reset();
        end_test(14);
        check_output("r5_unwritten", regs[5], 32'd0);

        // Reset raised during EXEC of the second addi cancels its write.
        apply_stimulus("reset_abort");
        rom[0] = enc_i(OP_ADDI, 1, 0, 5);
        rom[1] = enc_i(OP_ADDI, 2, 0, 7);
        expect_write(1, 32'd5, 1);
        release_reset();
        wait_cycle(2);
        @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        check_output("abort_we", {31'd0, ctrl_writeEnable}, 32'd0);
        check_output("abort_pc", address_imem, 32'd0);
        repeat (3) @(negedge clock);
        check_output("pending_writes", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
